// File: rtl/decimal_entry.sv
// Two-digit signed decimal keypad entry: accumulates BCD digits and a sign from
// edge-detected keys and commits a 7-bit two's-complement value on enter.
module decimal_entry (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       digit_key,
    input  logic [3:0] digit_in,
    input  logic       neg_key,
    input  logic       clear_key,
    input  logic       enter_key,
    output logic [6:0] val,
    output logic       val_valid,
    output logic       err,
    output logic       entry_neg,
    output logic [3:0] entry_tens,
    output logic [3:0] entry_ones,
    output logic [1:0] digit_count
);

    localparam int unsigned VAL_W = 7;
    localparam int unsigned DIG_W = 4;
    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DIG_W-1:0]   tens_q, tens_d;
    logic [DIG_W-1:0]   ones_q, ones_d;
    logic               neg_q, neg_d;
    logic [VAL_W-1:0]   val_q, val_d;
    logic               val_valid_q, val_valid_d;
    logic               err_q, err_d;
    logic               prev_digit_q, prev_neg_q, prev_clear_q, prev_enter_q;

    logic               digit_evt, neg_evt, clear_evt, enter_evt;
    logic [VAL_W-1:0]   mag;
    logic               enter_legal;

    assign digit_evt = digit_key & ~prev_digit_q;
    assign neg_evt   = neg_key   & ~prev_neg_q;
    assign clear_evt = clear_key & ~prev_clear_q;
    assign enter_evt = enter_key & ~prev_enter_q;

    // Magnitude never exceeds 99, so 7 bits hold it exactly.
    assign mag         = VAL_W'(tens_q) * VAL_W'(10) + VAL_W'(ones_q);
    assign enter_legal = neg_q ? (mag <= VAL_W'(64)) : (mag <= VAL_W'(63));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            tens_q       <= '0;
            ones_q       <= '0;
            neg_q        <= 1'b0;
            val_q        <= '0;
            val_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            prev_digit_q <= 1'b0;
            prev_neg_q   <= 1'b0;
            prev_clear_q <= 1'b0;
            prev_enter_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tens_q       <= tens_d;
            ones_q       <= ones_d;
            neg_q        <= neg_d;
            val_q        <= val_d;
            val_valid_q  <= val_valid_d;
            err_q        <= err_d;
            prev_digit_q <= digit_key;
            prev_neg_q   <= neg_key;
            prev_clear_q <= clear_key;
            prev_enter_q <= enter_key;
        end
    end

    // One event per cycle, priority clear > enter > digit > neg.
    always_comb begin
        state_d     = state_q;
        tens_d      = tens_q;
        ones_d      = ones_q;
        neg_d       = neg_q;
        val_d       = val_q;
        val_valid_d = 1'b0;
        err_d       = err_q;

        if (clear_evt) begin
            state_d = EMPTY;
            tens_d  = '0;
            ones_d  = '0;
            neg_d   = 1'b0;
            err_d   = 1'b0;
        end else if (enter_evt) begin
            if (enter_legal) begin
                val_d       = neg_q ? VAL_W'(VAL_W'(0) - mag) : mag;
                val_valid_d = 1'b1;
                err_d       = 1'b0;
            end else begin
                err_d = 1'b1;
            end
            state_d = EMPTY;
            tens_d  = '0;
            ones_d  = '0;
            neg_d   = 1'b0;
        end else if (digit_evt) begin
            if (digit_in > DIG_W'(9)) begin
                err_d = 1'b1;
            end else begin
                case (state_q)
                    EMPTY: begin
                        ones_d  = digit_in;
                        state_d = ONE;
                    end
                    ONE: begin
                        tens_d  = ones_q;
                        ones_d  = digit_in;
                        state_d = TWO;
                    end
                    default: err_d = 1'b1;
                endcase
            end
        end else if (neg_evt) begin
            neg_d = ~neg_q;
        end
    end

    assign val         = val_q;
    assign val_valid   = val_valid_q;
    assign err         = err_q;
    assign entry_neg   = neg_q;
    assign entry_tens  = tens_q;
    assign entry_ones  = ones_q;
    assign digit_count = CNT_W'(state_q);

endmodule
